// File: rtl/token_bucket_shaper_mc.sv
`default_nettype none
// ============================================================================
// Module   : token_bucket_shaper_mc
// Purpose  : Multi-channel token-bucket traffic shaper. Each input channel owns
//            a token bucket refilled by a shared timer. A channel's packet is
//            forwarded only when its bucket holds at least the packet length.
//            Eligible channels are round-robin arbitrated onto one registered
//            valid/ready output. Illegal lengths (0 or > CAP) are accepted and
//            discarded, with a one-cycle drop pulse.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_len/in_ready : per-channel packet request/accept
//            out_valid/out_ch/out_len/out_ready : registered egress
//            drop      : per-channel discard pulse (registered)
//            tok_level : per-channel bucket levels (registered)
// Revision : 1.0  initial release
// ============================================================================
module token_bucket_shaper_mc #(
    parameter int NCH      = 4,
    parameter int CAP      = 16,
    parameter int RATE     = 1,
    parameter int PERIOD   = 2,
    parameter int LEN_W    = 8,
    parameter int INIT_TOK = 0,
    localparam int TOK_W   = $clog2(CAP + 1),
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         in_valid,
    input  logic [NCH*LEN_W-1:0]   in_len,
    output logic [NCH-1:0]         in_ready,
    output logic                   out_valid,
    output logic [CH_W-1:0]        out_ch,
    output logic [LEN_W-1:0]       out_len,
    input  logic                   out_ready,
    output logic [NCH-1:0]         drop,
    output logic [NCH*TOK_W-1:0]   tok_level
);

    localparam int c_TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [c_TMR_W-1:0] r_timer;
    logic [TOK_W-1:0]   r_tokens [NCH];
    logic [CH_W-1:0]    r_rr;
    logic               r_out_valid;
    logic [CH_W-1:0]    r_out_ch;
    logic [LEN_W-1:0]   r_out_len;
    logic [NCH-1:0]     r_drop;

    logic [LEN_W-1:0]   w_len [NCH];
    logic [TOK_W-1:0]   w_tok_nxt [NCH];
    logic [NCH-1:0]     w_legal;
    logic [NCH-1:0]     w_elig;
    logic               w_refill;
    logic               w_slot_free;
    logic               w_grant_vld;
    logic [CH_W-1:0]    w_grant_ch;
    logic [LEN_W-1:0]   w_grant_len;

    assign w_refill    = (32'(r_timer) == 32'(PERIOD - 1));
    assign w_slot_free = !r_out_valid || out_ready;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        assign w_len[gi]   = in_len[gi*LEN_W +: LEN_W];
        assign w_legal[gi] = (w_len[gi] != '0) && (32'(w_len[gi]) <= 32'(CAP));
        assign w_elig[gi]  = in_valid[gi] && w_legal[gi] &&
                             (32'(r_tokens[gi]) >= 32'(w_len[gi]));
        // Illegal packets are swallowed regardless of arbitration or stall.
        assign in_ready[gi] = (in_valid[gi] && !w_legal[gi]) ||
                              (w_grant_vld && (w_grant_ch == CH_W'(gi)));
        assign tok_level[gi*TOK_W +: TOK_W] = r_tokens[gi];
    end

    // Round-robin pick: scan offsets from far to near so the last hit wins,
    // leaving the first eligible channel at or after r_rr as the grant.
    always_comb begin
        int               idx;
        logic [CH_W-1:0]  sel;
        w_grant_vld = 1'b0;
        w_grant_ch  = '0;
        idx         = 0;
        sel         = '0;
        if (w_slot_free) begin
            for (int k = NCH - 1; k >= 0; k--) begin
                idx = int'(r_rr) + k;
                if (idx >= NCH) begin
                    idx = idx - NCH;
                end
                sel = CH_W'(idx);
                if (w_elig[sel]) begin
                    w_grant_vld = 1'b1;
                    w_grant_ch  = sel;
                end
            end
        end
    end

    assign w_grant_len = w_len[w_grant_ch];

    // Subtract the granted length before saturating, so a refill landing in
    // the grant cycle is not lost when the bucket was already full.
    always_comb begin
        int lvl;
        lvl = 0;
        for (int i = 0; i < NCH; i++) begin
            lvl = int'(r_tokens[i]);
            if (w_refill) begin
                lvl = lvl + RATE;
            end
            if (w_grant_vld && (int'(w_grant_ch) == i)) begin
                lvl = lvl - int'(w_len[i]);
            end
            if (lvl > CAP) begin
                lvl = CAP;
            end
            w_tok_nxt[i] = TOK_W'(lvl);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer     <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_tokens[i] <= TOK_W'(INIT_TOK);
            end
            r_rr        <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_len   <= '0;
            r_drop      <= '0;
        end else begin
            r_timer <= w_refill ? '0 : r_timer + 1'b1;
            for (int i = 0; i < NCH; i++) begin
                r_tokens[i] <= w_tok_nxt[i];
            end
            r_drop <= in_valid & ~w_legal;
            if (w_grant_vld) begin
                r_out_valid <= 1'b1;
                r_out_ch    <= w_grant_ch;
                r_out_len   <= w_grant_len;
                r_rr        <= (int'(w_grant_ch) == NCH - 1) ? '0 : w_grant_ch + 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_len   = r_out_len;
    assign drop      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_token_bucket_shaper_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_token_bucket_shaper_mc
// Purpose  : Randomized self-checking bench for token_bucket_shaper_mc with a
//            behavioural bucket/arbiter reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_token_bucket_shaper_mc;

    localparam int NCH      = 4;
    localparam int CAP      = 16;
    localparam int RATE     = 1;
    localparam int PERIOD   = 2;
    localparam int LEN_W    = 8;
    localparam int INIT_TOK = 0;
    localparam int TOK_W    = $clog2(CAP + 1);
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       in_valid;
    logic [NCH*LEN_W-1:0] in_len;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [CH_W-1:0]      out_ch;
    logic [LEN_W-1:0]     out_len;
    logic                 out_ready;
    logic [NCH-1:0]       drop;
    logic [NCH*TOK_W-1:0] tok_level;

    token_bucket_shaper_mc #(
        .NCH(NCH), .CAP(CAP), .RATE(RATE), .PERIOD(PERIOD),
        .LEN_W(LEN_W), .INIT_TOK(INIT_TOK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_len    (in_len),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_len   (out_len),
        .out_ready (out_ready),
        .drop      (drop),
        .tok_level (tok_level)
    );

    always #5 clk = ~clk;

    // Reference model state
    int       m_tok [NCH];
    int       m_cycles;
    int       m_rr;
    bit       m_ov;
    int       m_och;
    int       m_olen;
    bit [NCH-1:0] m_drop;

    // Requester state
    bit       req_v   [NCH];
    int       req_len [NCH];
    bit       sticky;
    int       gen_pct;
    int       ordy_pct;

    int       n_vec;
    int       n_err;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input int l);
        return (l >= 1) && (l <= CAP);
    endfunction

    function automatic int tok_of(input int i);
        return int'(tok_level[i*TOK_W +: TOK_W]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) m_tok[i] = INIT_TOK;
        m_cycles = 0;
        m_rr     = 0;
        m_ov     = 0;
        m_och    = 0;
        m_olen   = 0;
        m_drop   = '0;
    endtask

    // Expected accepts this cycle and the granted channel (-1 if none).
    function automatic void model_comb(output bit [NCH-1:0] rdy, output int g);
        rdy = '0;
        g   = -1;
        for (int i = 0; i < NCH; i++)
            if (req_v[i] && !legal(req_len[i])) rdy[i] = 1'b1;
        if (!m_ov || out_ready) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_rr + k) % NCH;
                if (g < 0 && req_v[c] && legal(req_len[c]) && m_tok[c] >= req_len[c]) g = c;
            end
        end
        if (g >= 0) rdy[g] = 1'b1;
    endfunction

    task automatic model_edge(input int g);
        bit refill;
        // A refill lands on every PERIOD-th clock since reset.
        refill = ((m_cycles % PERIOD) == PERIOD - 1);
        m_cycles++;
        for (int i = 0; i < NCH; i++) begin
            int v;
            v = m_tok[i] + (refill ? RATE : 0) - ((i == g) ? req_len[i] : 0);
            m_tok[i] = (v > CAP) ? CAP : v;
            m_drop[i] = req_v[i] && !legal(req_len[i]);
        end
        if (g >= 0) begin
            m_ov   = 1;
            m_och  = g;
            m_olen = req_len[g];
            m_rr   = (g + 1) % NCH;
        end else if (out_ready) begin
            m_ov = 0;
        end
    endtask

    task automatic new_req(input int i);
        int r;
        r = $urandom_range(0, 99);
        if (r < 30) begin
            req_v[i] = 0;
        end else begin
            req_v[i] = 1;
            if (r < 37)      req_len[i] = 0;
            else if (r < 44) req_len[i] = $urandom_range(CAP + 1, 255);
            else             req_len[i] = $urandom_range(1, 6);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NCH; i++) begin
            in_valid[i] = req_v[i];
            in_len[i*LEN_W +: LEN_W] = LEN_W'(req_len[i]);
        end
        out_ready = ($urandom_range(0, 99) < ordy_pct);
    endtask

    // One clock: starts and ends just after a falling edge.
    task automatic step();
        bit [NCH-1:0] exp_rdy;
        int g;
        drive_inputs();
        #1;
        model_comb(exp_rdy, g);
        check_value("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        model_edge(g);
        #1;
        check_value("out_valid", out_valid, m_ov);
        if (m_ov) begin
            check_value("out_ch", out_ch, m_och);
            check_value("out_len", out_len, m_olen);
        end
        check_value("drop", drop, m_drop);
        for (int i = 0; i < NCH; i++) check_value("tok_level", tok_of(i), m_tok[i]);
        if (!sticky)
            for (int i = 0; i < NCH; i++) if (exp_rdy[i]) req_v[i] = 0;
        @(negedge clk);
        for (int i = 0; i < NCH; i++)
            if (!req_v[i] && ($urandom_range(0, 99) < gen_pct)) new_req(i);
    endtask

    task automatic set_all(input bit v, input int l);
        for (int i = 0; i < NCH; i++) begin
            req_v[i]   = v;
            req_len[i] = l;
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        sticky   = 0;
        gen_pct  = 0;
        ordy_pct = 100;
        set_all(0, 0);
        in_valid  = '0;
        in_len    = '0;
        out_ready = 1'b1;
        rst       = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state
        check_value("rst_out_valid", out_valid, 0);
        check_value("rst_drop", drop, 0);
        for (int i = 0; i < NCH; i++) check_value("rst_tok", tok_of(i), INIT_TOK);
        rst = 1'b0;

        // Channel 0, len 3, from reset
        req_v[0] = 1; req_len[0] = 3; sticky = 1;
        repeat (20) step();

        // Idle long enough to saturate every bucket
        set_all(0, 0); sticky = 0;
        repeat (40) step();
        for (int i = 0; i < NCH; i++) check_value("sat_tok", tok_of(i), CAP);

        // Channel 1 continuous len 4: burst then refill-limited
        req_v[1] = 1; req_len[1] = 4; sticky = 1;
        repeat (14) step();

        // All channels len 1 continuous: round-robin rotation
        set_all(0, 0);
        repeat (40) step();
        set_all(1, 1);
        repeat (12) step();

        // Illegal lengths on channel 2
        set_all(0, 0); sticky = 0;
        req_v[2] = 1; req_len[2] = 0;
        step();
        step();
        req_v[2] = 1; req_len[2] = 20;
        step();
        step();

        // Output stall for 10 cycles, then release
        set_all(1, 1); sticky = 1;
        repeat (8) step();
        ordy_pct = 0;
        repeat (10) step();
        ordy_pct = 100;
        repeat (4) step();

        // Randomized traffic
        sticky = 0; gen_pct = 50; ordy_pct = 70;
        repeat (3000) step();

        // Asynchronous reset in the middle of a stall
        sticky = 1; gen_pct = 0; ordy_pct = 100;
        set_all(1, 1);
        repeat (6) step();
        ordy_pct = 0;
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        check_value("arst_out_valid", out_valid, 0);
        check_value("arst_drop", drop, 0);
        for (int i = 0; i < NCH; i++) check_value("arst_tok", tok_of(i), INIT_TOK);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        ordy_pct = 100;
        repeat (12) step();

        // Random again after reset
        sticky = 0; gen_pct = 60; ordy_pct = 80;
        repeat (1000) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
